// File: rtl/ysyx_23060191_wbu_pkg.sv
// Shared widths, FSM encoding and captured-packet layout for the write-back unit.
`timescale 1ns/1ps
package ysyx_23060191_wbu_pkg;

  localparam int unsigned CPU_WIDTH        = 32;
  localparam int unsigned REG_ADDR_WIDTH   = 5;
  localparam int unsigned WBU_STATE_WIDTH  = 2;
  localparam int unsigned RETIRE_CNT_WIDTH = 64;

  typedef enum logic [WBU_STATE_WIDTH-1:0] {
    WBU_IDLE   = 2'd0,
    WBU_WRITE  = 2'd1,
    WBU_COMMIT = 2'd2
  } wbu_state_e;

  typedef struct packed {
    logic [CPU_WIDTH-1:0]      res;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      rd_wen;
    logic [CPU_WIDTH-1:0]      pc;
    logic [CPU_WIDTH-1:0]      dnpc;
  } wbu_pkt_t;

  // x0 is hardwired to zero, so writes targeting it are dropped.
  function automatic logic rf_write_allowed(input wbu_pkt_t pkt);
    return pkt.rd_wen && (pkt.rd != '0);
  endfunction

endpackage

// File: rtl/ysyx_23060191_retire_cnt.sv
// 64-bit retired-instruction counter with synchronous reset.
// Only built when YSYX_23060191_WBU_TRACE_EN is defined.
`timescale 1ns/1ps
`ifdef YSYX_23060191_WBU_TRACE_EN
module ysyx_23060191_retire_cnt
  import ysyx_23060191_wbu_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  output logic [RETIRE_CNT_WIDTH-1:0] cnt
);

  logic [RETIRE_CNT_WIDTH-1:0] cnt_q;
  logic [RETIRE_CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + RETIRE_CNT_WIDTH'(en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule
`endif

// File: rtl/ysyx_23060191_wbu.sv
// Write-back unit: captures an EXU result, writes rd for one cycle, then offers dnpc to the IFU.
// YSYX_23060191_WBU_TRACE_EN adds commit_pc and retire_cnt outputs for difftest/trace.
`timescale 1ns/1ps
module ysyx_23060191_wbu
  import ysyx_23060191_wbu_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        exu_valid,
  output logic                        exu_ready,
  input  logic [CPU_WIDTH-1:0]        exu_res,
  input  logic [REG_ADDR_WIDTH-1:0]   exu_rd,
  input  logic                        exu_rd_wen,
  input  logic [CPU_WIDTH-1:0]        exu_pc,
  input  logic [CPU_WIDTH-1:0]        exu_dnpc,
  output logic                        rf_wen,
  output logic [REG_ADDR_WIDTH-1:0]   rf_waddr,
  output logic [CPU_WIDTH-1:0]        rf_wdata,
  output logic                        ifu_valid,
  input  logic                        ifu_ready,
  output logic [CPU_WIDTH-1:0]        ifu_dnpc
`ifdef YSYX_23060191_WBU_TRACE_EN
  ,
  output logic [CPU_WIDTH-1:0]        commit_pc,
  output logic [RETIRE_CNT_WIDTH-1:0] retire_cnt
`endif
);

  wbu_state_e                state_q, state_d;
  wbu_pkt_t                  cap_q, cap_d;
  logic                      rf_wen_q, rf_wen_d;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [CPU_WIDTH-1:0]      rf_wdata_q, rf_wdata_d;
  logic                      ifu_valid_q, ifu_valid_d;
  logic [CPU_WIDTH-1:0]      ifu_dnpc_q, ifu_dnpc_d;

  // Next state, capture, and output values decoded from the state being entered.
  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    rf_wen_d    = 1'b0;
    rf_waddr_d  = '0;
    rf_wdata_d  = '0;
    ifu_valid_d = 1'b0;
    ifu_dnpc_d  = ifu_dnpc_q;

    case (state_q)
      WBU_IDLE: begin
        if (exu_valid) begin
          cap_d.res    = exu_res;
          cap_d.rd     = exu_rd;
          cap_d.rd_wen = exu_rd_wen;
          cap_d.pc     = exu_pc;
          cap_d.dnpc   = exu_dnpc;
          state_d      = WBU_WRITE;
        end
      end
      WBU_WRITE: begin
        state_d = WBU_COMMIT;
      end
      WBU_COMMIT: begin
        if (ifu_ready) begin
          state_d = WBU_IDLE;
        end
      end
      default: begin
        state_d = WBU_IDLE;
      end
    endcase

    if (state_d == WBU_WRITE) begin
      rf_wen_d   = rf_write_allowed(cap_d);
      rf_waddr_d = cap_d.rd;
      rf_wdata_d = cap_d.res;
    end

    if (state_d == WBU_COMMIT) begin
      ifu_valid_d = 1'b1;
      ifu_dnpc_d  = cap_d.dnpc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WBU_IDLE;
      cap_q       <= '0;
      rf_wen_q    <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      ifu_valid_q <= 1'b0;
      ifu_dnpc_q  <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      rf_wen_q    <= rf_wen_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      ifu_valid_q <= ifu_valid_d;
      ifu_dnpc_q  <= ifu_dnpc_d;
    end
  end

  // Gated by rst so EXU sees the unit as busy for the whole reset pulse.
  assign exu_ready = (state_q == WBU_IDLE) && !rst;
  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign ifu_valid = ifu_valid_q;
  assign ifu_dnpc  = ifu_dnpc_q;

`ifdef YSYX_23060191_WBU_TRACE_EN
  logic retire_en_c;

  assign retire_en_c = (state_q == WBU_COMMIT) && ifu_ready;
  assign commit_pc   = cap_q.pc;

  ysyx_23060191_retire_cnt u_retire_cnt (
    .clk (clk),
    .rst (rst),
    .en  (retire_en_c),
    .cnt (retire_cnt)
  );
`else
  // The captured pc only feeds the trace outputs.
  logic unused_pc_c;
  assign unused_pc_c = ^cap_q.pc;
`endif

endmodule
